// File: rtl/otter_pkg.sv
// Shared Otter MCU core types and widths.
// The register file and the decode/writeback stages all use these.
package otter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREGS      = 1 << REG_ADDR_W;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/otter_rfile.sv
// RV32I integer register file: two combinational read ports and one synchronous write port.
// x0 is hardwired to zero, and a read of the register being written returns the old value.
module otter_rfile
  import otter_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  reg_addr_t i_r_addr1,
  input  reg_addr_t i_r_addr2,
  input  logic      i_w_en,
  input  reg_addr_t i_w_addr,
  input  word_t     i_w_data,
  output word_t     o_r_rs1,
  output word_t     o_r_rs2
);

  // Entry 0 is forced to zero so it reduces to constants in synthesis.
  word_t rf_q [NREGS] = '{default: '0};
  word_t rf_d [NREGS];

  always_comb begin
    rf_d = rf_q;
    if (i_w_en && !is_x0(i_w_addr)) begin
      rf_d[i_w_addr] = i_w_data;
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  // No write-first bypass; forwarding is handled by the pipeline.
  assign o_r_rs1 = is_x0(i_r_addr1) ? '0 : rf_q[i_r_addr1];
  assign o_r_rs2 = is_x0(i_r_addr2) ? '0 : rf_q[i_r_addr2];

endmodule

// File: tb/tb_otter_rfile.sv
// Scoreboard bench for otter_rfile: stimulus queues expected read values, the monitor compares.
module tb_otter_rfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  r_addr1, r_addr2, w_addr;
  logic        w_en;
  logic [31:0] w_data;
  logic [31:0] rs1, rs2;

  otter_rfile dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_r_addr1(r_addr1),
    .i_r_addr2(r_addr2),
    .i_w_en   (w_en),
    .i_w_addr (w_addr),
    .i_w_data (w_data),
    .o_r_rs1  (rs1),
    .o_r_rs2  (rs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  logic obs_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: whenever stimulus flags the read outputs as presented, drain the scoreboard.
  always @(negedge clk) begin
    if (obs_valid) begin
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e   = sb.pop_front();
        got = (e.port == 1) ? rs1 : rs2;
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s rs%0d got %h want %h", e.name, e.port, got, e.exp);
        end
      end
    end
  end

  task automatic push(input string name, input int port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Called just after a posedge; leaves the bench just after the next posedge.
  task automatic present();
    obs_valid = 1'b1;
    @(negedge clk);
    #1 obs_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2, input string name);
    r_addr1 = a1;
    r_addr2 = a2;
    push(name, 1, e1);
    push(name, 2, e2);
    present();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
    w_en   = en;
    w_addr = a;
    w_data = d;
    @(posedge clk);
    #1 w_en = 1'b0;
  endtask

  logic [31:0] pats [8];

  initial begin
    pats = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555,
             32'h1234_5678, 32'h8765_4321, 32'hF0F0_F0F0, 32'h0F0F_0F0F};
    rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0; r_addr1 = '0; r_addr2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_sweep");

    wr(5'd1, 32'hDEAD_BEEF, 1'b1);
    rd(5'd1, 5'd0, 32'hDEAD_BEEF, 32'h0, "x1_write");
    wr(5'd31, 32'hFFFF_FFFF, 1'b1);
    rd(5'd31, 5'd1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "x31_write");

    wr(5'd0, 32'hDEAD_BEEF, 1'b1);
    rd(5'd0, 5'd0, 32'h0, 32'h0, "x0_discard");
    wr(5'd3, 32'hABCD_EF00, 1'b1);
    wr(5'd3, 32'h1111_1111, 1'b0);
    rd(5'd3, 5'd3, 32'hABCD_EF00, 32'hABCD_EF00, "wen_low_hold");

    wr(5'd5, 32'h1234_5678, 1'b1);
    wr(5'd10, 32'h8765_4321, 1'b1);
    rd(5'd5, 5'd10, 32'h1234_5678, 32'h8765_4321, "dual_read");

    // Read-during-write: x16 shows its old value in the write cycle.
    wr(5'd15, 32'hCAFE_BABE, 1'b1);
    wr(5'd16, 32'h0000_0016, 1'b1);
    w_en = 1'b1; w_addr = 5'd16; w_data = 32'hDEAD_C0DE;
    r_addr1 = 5'd15; r_addr2 = 5'd16;
    push("rdw_same_cycle", 1, 32'hCAFE_BABE);
    push("rdw_same_cycle", 2, 32'h0000_0016);
    present();
    w_en = 1'b0;
    rd(5'd15, 5'd16, 32'hCAFE_BABE, 32'hDEAD_C0DE, "rdw_after_edge");

    for (int i = 0; i < 8; i++) wr(5'(20 + i), pats[i], 1'b1);
    for (int i = 0; i < 8; i++) rd(5'(20 + i), 5'(27 - i), pats[i], pats[7 - i], "pattern");

    for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + i, 1'b1);
    for (int i = 1; i < 32; i++) rd(5'(i), 5'(32 - i), 32'h1000_0000 + i,
                                    32'h1000_0000 + (32 - i), "full_sweep");
    rd(5'd0, 5'd0, 32'h0, 32'h0, "x0_after_sweep");

    // Async reset: outputs must be zero before any rising edge, and writes are blocked.
    #1 rst = 1'b1;
    r_addr1 = 5'd7; r_addr2 = 5'd31;
    #1;
    checks++;
    if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_immediate got %h/%h want 0/0", rs1, rs2);
    end
    w_en = 1'b1; w_addr = 5'd7; w_data = 32'h7777_7777;
    rd(5'd7, 5'd31, 32'h0, 32'h0, "write_during_reset");
    w_en = 1'b0;
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_hold_sweep");
    rst = 1'b0;
    rd(5'd7, 5'd1, 32'h0, 32'h0, "after_reset_release");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
